sha256_mem_responder: RTL and testbench

- Memory-side responder for the SHA-256 core's memory master port.
- Word-addressed synchronous RAM that serves the core's message reads (1-cycle latency) and accepts its digest writes.
- Host port loads message words and reads results back; core owns the RAM from start until done, and the host owns it otherwise.
- Captures the 8-word digest as the core writes it and raises digest_valid when all 8 words have landed.

---
 rtl/sha256_mem_responder_if.sv | 39 +++
 rtl/sha256_mem_responder.sv | 151 +++++++++++++++
 tb/tb_sha256_mem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_mem_responder_if.sv
// rtl/sha256_mem_responder_if.sv - core/host bus bundle for the SHA-256 memory responder
interface sha256_mem_responder_if;
   logic         core_start;
   logic         core_done;
   logic [15:0]  message_addr;
   logic [15:0]  output_addr;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_write_data;
   logic [31:0]  mem_read_data;
   logic         host_req;
   logic         host_we;
   logic [15:0]  host_addr;
   logic [31:0]  host_wdata;
   logic         host_gnt;
   logic [31:0]  host_rdata;
   logic         host_rvalid;
   logic [255:0] digest;
   logic         digest_valid;
   logic         err;

   // Responder side: the RAM block
   modport slave (
      input  core_start, core_done, message_addr, output_addr,
      input  mem_we, mem_addr, mem_write_data,
      input  host_req, host_we, host_addr, host_wdata,
      output mem_read_data, host_gnt, host_rdata, host_rvalid,
      output digest, digest_valid, err
   );

   // Driver side: core plus host
   modport master (
      output core_start, core_done, message_addr, output_addr,
      output mem_we, mem_addr, mem_write_data,
      output host_req, host_we, host_addr, host_wdata,
      input  mem_read_data, host_gnt, host_rdata, host_rvalid,
      input  digest, digest_valid, err
   );
endinterface

// File: rtl/sha256_mem_responder.sv
// rtl/sha256_mem_responder.sv - shared RAM, ownership FSM and digest capture for the SHA-256 core (optional SHA_RESP_PROTECT_EN)
module sha256_mem_responder #(
   parameter int          DEPTH        = 256,
   parameter int          NUM_OF_WORDS = 20,
   parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
   input logic                   clk,
   input logic                   reset,
   sha256_mem_responder_if.slave bus
);
   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);
   localparam logic [16:0] NUM_L   = 17'(NUM_OF_WORDS);

   localparam logic [1:0] ST_HOST = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [7:0]  mask_q, mask_d;
   logic        err_q, err_d;
   logic [31:0] ram_q [DEPTH];
   logic [31:0] digest_q [8];
   logic [31:0] mem_read_data_q;
   logic [31:0] host_rdata_q;
   logic        host_rvalid_q;

   logic          host_gnt;
   logic          core_active;
   logic          core_in_range;
   logic          host_in_range;
   logic          host_acc;
   logic          host_rd;
   logic          host_wr;
   logic          core_wr;
   logic          capture;
   logic          protect_hit;
   logic [15:0]   digest_off;
   logic [AW-1:0] core_idx;
   logic [AW-1:0] host_idx;

   assign host_gnt      = (state_q == ST_HOST);
   assign core_active   = !host_gnt;
   assign core_in_range = {1'b0, bus.mem_addr} < DEPTH_L;
   assign host_in_range = {1'b0, bus.host_addr} < DEPTH_L;
   assign core_idx      = bus.mem_addr[AW-1:0];
   assign host_idx      = bus.host_addr[AW-1:0];

   // 16-bit subtraction makes a window that straddles 16'hFFFF wrap naturally
   assign digest_off = bus.mem_addr - bus.output_addr;
   assign capture    = core_active && bus.mem_we && (digest_off < 16'd8);

`ifdef SHA_RESP_PROTECT_EN
   logic [15:0] msg_off;
   assign msg_off     = bus.mem_addr - bus.message_addr;
   assign protect_hit = {1'b0, msg_off} < NUM_L;
`else
   logic unused_protect;
   assign unused_protect = ^{bus.message_addr, NUM_L};
   assign protect_hit    = 1'b0;
`endif

   assign host_acc = bus.host_req && host_gnt;
   assign host_rd  = host_acc && !bus.host_we;
   assign host_wr  = host_acc && bus.host_we && host_in_range;
   assign core_wr  = core_active && bus.mem_we && core_in_range && !protect_hit;

   // Ownership FSM: host until start, then core until it reports done again
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOST: if (bus.core_start) state_d = ST_ARM;
         ST_ARM:  if (!bus.core_done) state_d = ST_RUN;
         ST_RUN:  if (bus.core_done)  state_d = ST_HOST;
         default: state_d = ST_HOST;
      endcase
   end

   // Digest slot mask: cleared by an accepted start, filled by window writes
   always_comb begin
      mask_d = mask_q;
      if (host_gnt && bus.core_start) mask_d = 8'h00;
      else if (capture)               mask_d = mask_q | (8'h01 << digest_off[2:0]);
   end

   // Sticky error: the core port reads every active cycle, so its address is checked every active cycle
   always_comb begin
      err_d = err_q
            | (core_active && !core_in_range)
            | (host_acc && !host_in_range)
            | (core_active && bus.mem_we && protect_hit);
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_HOST;
         mask_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   // RAM write port; the two owners are never active together
   always_ff @(posedge clk) begin
      if (core_wr)      ram_q[core_idx] <= bus.mem_write_data;
      else if (host_wr) ram_q[host_idx] <= bus.host_wdata;
   end

   // Core read data: registered, refreshed every cycle the core owns the RAM
   always_ff @(posedge clk) begin
      if (reset)            mem_read_data_q <= '0;
      else if (core_active) mem_read_data_q <= core_in_range ? ram_q[core_idx] : OOR_DATA;
   end

   // Host read response, one cycle after an accepted read
   always_ff @(posedge clk) begin
      if (reset) begin
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         host_rvalid_q <= host_rd;
         if (host_rd) host_rdata_q <= host_in_range ? ram_q[host_idx] : OOR_DATA;
      end
   end

   // Digest words follow window writes even when the RAM write itself is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 8; k++) digest_q[k] <= '0;
      end else if (capture) begin
         digest_q[digest_off[2:0]] <= bus.mem_write_data;
      end
   end

   // Pack digest with word 0 in the most significant position
   always_comb begin
      bus.digest = '0;
      for (int k = 0; k < 8; k++) bus.digest[255-32*k -: 32] = digest_q[k];
   end

   assign bus.mem_read_data = mem_read_data_q;
   assign bus.host_gnt      = host_gnt;
   assign bus.host_rdata    = host_rdata_q;
   assign bus.host_rvalid   = host_rvalid_q;
   assign bus.digest_valid  = (mask_q == 8'hFF);
   assign bus.err           = err_q;
endmodule

// File: tb/tb_sha256_mem_responder.sv
// tb/tb_sha256_mem_responder.sv - scoreboard bench for sha256_mem_responder
module tb_sha256_mem_responder;
   localparam int          DEPTH = 256;
   localparam int          NUM   = 20;
   localparam logic [31:0] OOR   = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sha256_mem_responder_if bus();

   sha256_mem_responder #(.DEPTH(DEPTH), .NUM_OF_WORDS(NUM), .OOR_DATA(OOR)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 0;
   exp_t        hq[$];
   exp_t        cq[$];
   logic [31:0] ref_mem [int];
   int          written[$];
   int          phase = 0;            // 0 host owns, 1 armed, 2 running
   logic [31:0] exp_dig [8];
   logic [7:0]  exp_mask = 8'h00;
   bit          exp_err = 0;
   int          out_base = 0;
   int          msg_base = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int c, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      return e;
   endfunction

   function automatic logic [255:0] dig_model();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[255-32*k -: 32] = exp_dig[k];
      return v;
   endfunction

   function automatic bit protected_addr(input int a);
`ifdef SHA_RESP_PROTECT_EN
      return ((a - msg_base + 65536) % 65536) < NUM;
`else
      return (a < 0);
`endif
   endfunction

   function automatic logic [31:0] model_read(input int a);
      if (a >= DEPTH) return OOR;
      return ref_mem[a];
   endfunction

   // Scoreboard monitor: compares whenever an expected response falls due
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (hq.size() > 0 && hq[0].cyc == cyc) begin
            e = hq.pop_front();
            chk("host_rvalid", 256'(bus.host_rvalid), 256'(1'b1));
            chk("host_rdata", 256'(bus.host_rdata), 256'(e.data));
         end else begin
            chk("host_rvalid_idle", 256'(bus.host_rvalid), 256'(1'b0));
         end
         if (cq.size() > 0 && cq[0].cyc == cyc) begin
            e = cq.pop_front();
            chk("mem_read_data", 256'(bus.mem_read_data), 256'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      phase    = 0;
      exp_mask = 8'h00;
      exp_err  = 0;
      for (int k = 0; k < 8; k++) exp_dig[k] = 32'h0;
   endtask

   task automatic do_reset(input bit with_host_read);
      reset = 1'b1;
      if (with_host_read) begin
         bus.host_req  = 1'b1;
         bus.host_we   = 1'b0;
         bus.host_addr = 16'd0;
      end
      tick();
      bus.host_req = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic host_write(input int a, input logic [31:0] d);
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 16'(a);
      bus.host_wdata = d;
      if (phase == 0) begin
         if (a < DEPTH) begin
            ref_mem[a] = d;
         end else begin
            exp_err = 1;
         end
      end
      tick();
      bus.host_req = 1'b0;
   endtask

   task automatic host_read(input int a);
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 16'(a);
      if (phase == 0) begin
         hq.push_back(mk(cyc + 1, model_read(a)));
         if (a >= DEPTH) exp_err = 1;
      end
      tick();
      bus.host_req = 1'b0;
   endtask

   task automatic core_read(input int a);
      bus.mem_we   = 1'b0;
      bus.mem_addr = 16'(a);
      if (phase != 0) begin
         cq.push_back(mk(cyc + 1, model_read(a)));
         if (a >= DEPTH) exp_err = 1;
      end
      tick();
      bus.mem_addr = 16'd0;
   endtask

   task automatic core_write(input int a, input logic [31:0] d);
      int off;
      off = (a - out_base + 65536) % 65536;
      bus.mem_we         = 1'b1;
      bus.mem_addr       = 16'(a);
      bus.mem_write_data = d;
      if (phase != 0) begin
         if (a >= DEPTH || ref_mem.exists(a)) cq.push_back(mk(cyc + 1, model_read(a)));
         if (a >= DEPTH)             exp_err = 1;
         else if (protected_addr(a)) exp_err = 1;
         else                        ref_mem[a] = d;
         if (off < 8) begin
            exp_dig[off]  = d;
            exp_mask[off] = 1'b1;
         end
      end
      tick();
      bus.mem_we   = 1'b0;
      bus.mem_addr = 16'd0;
   endtask

   task automatic start_core();
      bus.core_start = 1'b1;
      if (phase == 0) begin
         phase    = 1;
         exp_mask = 8'h00;
      end
      tick();
      bus.core_start = 1'b0;
   endtask

   task automatic set_done(input bit v);
      bus.core_done = v;
      if (phase == 1 && !v)     phase = 2;
      else if (phase == 2 && v) phase = 0;
      tick();
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_digest_valid"}, 256'(bus.digest_valid), 256'(&exp_mask));
      chk({tag, "_err"}, 256'(bus.err), 256'(exp_err));
      chk({tag, "_digest"}, bus.digest, dig_model());
   endtask

   initial begin
      logic [31:0] d;
      int          a;
      bus.core_start     = 1'b0;
      bus.core_done      = 1'b1;
      bus.message_addr   = 16'd0;
      bus.output_addr    = 16'h0020;
      bus.mem_we         = 1'b0;
      bus.mem_addr       = 16'd0;
      bus.mem_write_data = 32'h0;
      bus.host_req       = 1'b0;
      bus.host_we        = 1'b0;
      bus.host_addr      = 16'd0;
      bus.host_wdata     = 32'h0;
      msg_base = 0;
      out_base = 16'h0020;

      do_reset(1'b0);
      mon_en = 1;
      chk("rst_host_gnt", 256'(bus.host_gnt), 256'(1'b1));
      chk("rst_mem_read_data", 256'(bus.mem_read_data), 256'(0));
      chk("rst_host_rdata", 256'(bus.host_rdata), 256'(0));
      chk_status("rst");

      // Host load and readback, then random host traffic
      for (int n = 0; n < 20; n++) host_write(n, 32'h11110000 + n);
      host_read(5);
      for (int i = 0; i < 12; i++) begin
         a = 100 + $urandom_range(0, 99);
         host_write(a, $urandom);
         written.push_back(a);
      end
      for (int i = 0; i < 6; i++) host_read(written[$urandom_range(0, written.size() - 1)]);

      // Core ownership and read latency
      start_core();
      chk("arm_host_gnt", 256'(bus.host_gnt), 256'(1'b0));
      set_done(1'b0);
      core_read(7);
      for (int i = 0; i < 4; i++) core_read(written[$urandom_range(0, written.size() - 1)]);
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 16'd5;
      bus.host_wdata = 32'h0BAD0BAD;
      chk("run_host_gnt", 256'(bus.host_gnt), 256'(1'b0));
      tick();
      bus.host_req = 1'b0;
      core_read(5);
      core_write(written[0], $urandom);
      core_read(written[0]);

      // Digest capture, including an overwrite of one slot
      for (int k = 0; k < 8; k++) begin
         core_write(16'h0020 + k, 32'hA0 + k);
         chk("cap_digest_valid", 256'(bus.digest_valid), 256'(&exp_mask));
      end
      chk("digest_word0", 256'(bus.digest[255:224]), 256'(32'hA0));
      chk_status("cap");
      core_write(16'h0023, $urandom);
      chk_status("overwrite");
      set_done(1'b1);
      chk("done_host_gnt", 256'(bus.host_gnt), 256'(1'b1));
      start_core();
      chk_status("restart");

      // Out of range on both ports
      set_done(1'b0);
      core_read(16'h0100);
      chk("oor_core_err", 256'(bus.err), 256'(exp_err));
      set_done(1'b1);
      host_write(16'h0200, 32'h55555555);
      host_read(0);
      host_read(16'h0300);
      tick();
      chk_status("oor");
      do_reset(1'b1);
      chk("rst2_host_rvalid", 256'(bus.host_rvalid), 256'(1'b0));
      chk_status("rst2");

      // Wrapped digest window and start coinciding with a host write
      out_base        = 16'hFFFC;
      bus.output_addr = 16'hFFFC;
      d = $urandom;
      bus.core_start = 1'b1;
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 16'd40;
      bus.host_wdata = d;
      ref_mem[40] = d;
      phase    = 1;
      exp_mask = 8'h00;
      tick();
      bus.core_start = 1'b0;
      bus.host_req   = 1'b0;
      chk("start_host_gnt", 256'(bus.host_gnt), 256'(1'b0));
      set_done(1'b0);
      core_read(40);
      core_write(16'h0002, $urandom);
      core_write(16'hFFFE, $urandom);
      core_write(16'hFFFB, $urandom);
      core_write(16'h0024, $urandom);
      chk_status("wrap");
      set_done(1'b1);
      do_reset(1'b0);

      // Write into the message area
      start_core();
      set_done(1'b0);
      core_write(3, 32'hC0FFEE03);
      core_read(3);
      tick();
      chk_status("protect");
      set_done(1'b1);

      tick();
      tick();
      chk("host_queue_drained", 256'(hq.size()), 256'(0));
      chk("core_queue_drained", 256'(cq.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
